// File: rtl/tt_um_digital_playground.sv
// rtl/tt_um_digital_playground.sv - playground tile: free counter, 8-bit LFSR, edge and change counters
module tt_um_digital_playground (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [7:0] cnt;
    logic [7:0] lfsr;
    logic [3:0] pcnt;
    logic [3:0] tcnt;
    logic       p_s1, p_s2, p_s3;
    logic       t_s1, t_s2, t_s3;
    logic       rise1;
    logic       chg2;
    logic       lfsr_fb;

    // s1/s2 resolve metastability; s3 is the previous clean sample for edge detection
    assign rise1   = p_s2 & ~p_s3;
    assign chg2    = t_s2 ^ t_s3;
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // rst_n is active-high despite its harness-imposed name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt  <= 8'h00;
            lfsr <= 8'h01;
            pcnt <= 4'h0;
            tcnt <= 4'h0;
            p_s1 <= 1'b0;
            p_s2 <= 1'b0;
            p_s3 <= 1'b0;
            t_s1 <= 1'b0;
            t_s2 <= 1'b0;
            t_s3 <= 1'b0;
        end else if (ena) begin
            p_s1 <= ui_in[1];
            p_s2 <= p_s1;
            p_s3 <= p_s2;
            t_s1 <= ui_in[2];
            t_s2 <= t_s1;
            t_s3 <= t_s2;
            if (rise1) begin
                pcnt <= pcnt + 4'd1;
            end
            if (chg2) begin
                tcnt <= tcnt + 4'd1;
            end
            // run enable is treated as quasi-static, so it is not synchronized
            if (ui_in[0]) begin
                cnt  <= cnt + 8'd1;
                lfsr <= {lfsr[6:0], lfsr_fb};
            end
        end
    end

    assign uo_out  = ui_in[3] ? lfsr : cnt;
    assign uio_out = {pcnt, tcnt};
    assign uio_oe  = 8'hFF;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_digital_playground.sv
// tb/tb_tt_um_digital_playground.sv - self-checking bench for tt_um_digital_playground
module tb_tt_um_digital_playground;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] ui;
        logic       en;
        int         n;
        logic [7:0] uo;
        logic [7:0] uio;
    } vec_t;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    // independent reference state for the randomized scoreboard phase
    logic [7:0] m_cnt, m_lfsr;
    logic [3:0] m_p, m_t;
    logic [2:0] m_ps, m_ts;

    tt_um_digital_playground dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [7:0] r;
        checks   = 0;
        failures = 0;

        // ui, ena, cycles, expected uo_out, expected uio_out -- state carries row to row
        vecs[0]  = '{8'h01, 1'b1, 5,   8'h05, 8'h00};
        vecs[1]  = '{8'h09, 1'b1, 0,   8'h23, 8'h00};
        vecs[2]  = '{8'h08, 1'b1, 3,   8'h23, 8'h00};
        vecs[3]  = '{8'h00, 1'b1, 0,   8'h05, 8'h00};
        vecs[4]  = '{8'h01, 1'b1, 251, 8'h00, 8'h00};
        vecs[5]  = '{8'h08, 1'b1, 0,   8'h02, 8'h00};
        vecs[6]  = '{8'h02, 1'b1, 1,   8'h00, 8'h00};
        vecs[7]  = '{8'h00, 1'b1, 1,   8'h00, 8'h00};
        vecs[8]  = '{8'h00, 1'b1, 1,   8'h00, 8'h10};
        vecs[9]  = '{8'h03, 1'b1, 1,   8'h01, 8'h10};
        vecs[10] = '{8'h01, 1'b1, 2,   8'h03, 8'h20};
        vecs[11] = '{8'h02, 1'b0, 10,  8'h03, 8'h20};
        vecs[12] = '{8'hF3, 1'b0, 5,   8'h03, 8'h20};
        vecs[13] = '{8'h01, 1'b1, 1,   8'h04, 8'h20};
        vecs[14] = '{8'h02, 1'b1, 3,   8'h04, 8'h30};
        vecs[15] = '{8'h00, 1'b1, 3,   8'h04, 8'h30};

        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'hF6;
        uio_in = 8'h5A;
        #1;
        chk("reset_uo_mode0", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h00);
        chk("reset_oe", uio_oe, 8'hFF);
        ui_in = 8'h08;
        #1;
        chk("reset_uo_mode1", uo_out, 8'h01);
        ena   = 1'b1;
        ui_in = 8'h07;
        run(4);
        chk("reset_hold_uo", uo_out, 8'h00);
        chk("reset_hold_uio", uio_out, 8'h00);

        ui_in = 8'h00;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ui_in = vecs[i].ui;
            ena   = vecs[i].en;
            if (vecs[i].n > 0) run(vecs[i].n);
            else #1;
            chk($sformatf("vec%0d_uo", i), uo_out, vecs[i].uo);
            chk($sformatf("vec%0d_uio", i), uio_out, vecs[i].uio);
        end

        // short pulse that no edge samples high
        #2 ui_in = 8'h02;
        #1 ui_in = 8'h00;
        run(4);
        chk("glitch_ignored", uio_out, 8'h30);

        for (int k = 1; k <= 18; k++) begin
            ui_in[2] = ~ui_in[2];
            run(2);
            if (k == 10) begin
                run(3);
                chk("toggle_10", uio_out, 8'h3A);
            end
        end
        run(3);
        chk("toggle_18_wrap", uio_out, 8'h32);

        // asynchronous reset between edges
        ui_in = 8'h01;
        #2 rst_n = 1'b1;
        #1;
        chk("async_rst_uo", uo_out, 8'h00);
        chk("async_rst_uio", uio_out, 8'h00);
        run(1);
        rst_n = 1'b0;
        run(1);
        chk("post_rst_step", uo_out, 8'h01);

        m_cnt  = 8'h01;
        m_lfsr = 8'h02;
        m_p    = 4'h0;
        m_t    = 4'h0;
        m_ps   = 3'b000;
        m_ts   = 3'b000;
        for (int c = 0; c < 200; c++) begin
            r     = 8'($urandom);
            ui_in = r;
            ena   = ($urandom_range(0, 7) != 0);
            if (ena) begin
                if (m_ps[1] && !m_ps[2]) m_p = m_p + 4'd1;
                if (m_ts[1] != m_ts[2]) m_t = m_t + 4'd1;
                m_ps = {m_ps[1:0], r[1]};
                m_ts = {m_ts[1:0], r[2]};
                if (r[0]) begin
                    m_cnt  = m_cnt + 8'd1;
                    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
                end
            end
            e.uo  = r[3] ? m_lfsr : m_cnt;
            e.uio = {m_p, m_t};
            sb.push_back(e);
            run(1);
            e = sb.pop_front();
            chk($sformatf("sb%0d_uo", c), uo_out, e.uo);
            chk($sformatf("sb%0d_uio", c), uio_out, e.uio);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
